uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate; BPS_CNT = CLK_FREQ/BAUD (integer division), BPS_HALF = BPS_CNT/2.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rs232_rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  8  last received byte, LSB first on line.
REQ-007 SHALL have port rx_int  output  1  high while a validated frame is in reception; falling edge marks rx_data valid.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch (see Configuration).

Function
REQ-010 SHALL pass rs232_rx through a 2-flop synchronizer plus one history flop; start edge = synced high-to-low transition.
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE SHALL ignore a line held low; only a start edge moves to START and clears the bit-period counter.
REQ-013 The bit-period counter SHALL count 0..BPS_CNT-1 and wrap; the sample point is count == BPS_HALF.
REQ-014 START: at the sample point, line low -> assert rx_int, go DATA; line high -> false start, return IDLE, rx_int stays low, no outputs change.
REQ-015 DATA: SHALL sample 8 bits at successive sample points into a shift register, bit 0 first; after bit 7 go PARITY (if compiled) else STOP.
REQ-016 STOP: at the sample point SHALL copy the shift register to rx_data, deassert rx_int, and return to IDLE in the same cycle (half bit early, allowing back-to-back frames).
REQ-017 frame_err SHALL pulse in the cycle rx_int falls when the stop sample is low; rx_data is still updated.
REQ-018 rx_data SHALL change only in the cycle rx_int falls and SHALL hold between frames.
REQ-019 A start edge arriving during the final half stop bit SHALL be detected in IDLE on the next cycle.
REQ-020 Latency: rx_int falls BPS_HALF + 9*BPS_CNT (+BPS_CNT with parity) cycles after the synced start edge, +/-1 cycle.

Reset
REQ-021 On rst_n low: FSM to IDLE, counters 0, synchronizer flops 1, rx_data 8'h00, rx_int 0, frame_err 0, parity_err 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately; the frame SHALL NOT complete after release, and the next start edge after release SHALL be received normally.

Configuration
REQ-023 Macro UART_RX_PARITY_EN SHALL control the parity stage.
REQ-024 Defined: PARITY state SHALL sample one even-parity bit after bit 7; mismatch pulses parity_err in the cycle rx_int falls; rx_data still updated.
REQ-025 Undefined: PARITY state unreachable/absent, frame is 10 bits, parity_err tied 0.

Verification (CLK_FREQ 50000000, BAUD 9600: BPS_CNT 5208, BPS_HALF 2604)
REQ-026 Frame 0x55, stop 1 -> rx_data 8'h55 at rx_int fall, frame_err 0, rx_int fall 49476 +/-3 cycles after line start edge (no parity).
REQ-027 Two back-to-back frames 0xA3, 0x0F with no idle gap -> two rx_int falls, rx_data 8'hA3 then 8'h0F.
REQ-028 Low glitch of 1000 cycles on idle line -> rx_int stays 0, rx_data unchanged.
REQ-029 Frame 0x81 with stop bit 0, line then held low 20 bit times -> rx_data 8'h81, one frame_err pulse, no further rx_int activity until line high then low.
REQ-030 rst_n pulsed low during bit 4 of 0x3C, then frame 0xC3 sent -> only 8'hC3 delivered, rx_data 8'h00 before it.
REQ-031 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> rx_data 8'h07, one parity_err pulse; parity bit 1 -> parity_err 0.

Source files
------------

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver core, 8 data bits, LSB first, one stop bit
// Optional even-parity stage is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_core #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int BPS_CNT  = CLK_FREQ / BAUD;
  localparam int BPS_HALF = BPS_CNT / 2;
  localparam int CW       = $clog2(BPS_CNT);

  localparam logic [CW-1:0] CNT_LAST   = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(BPS_HALF);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          start_edge;
  logic          sample;

  assign start_edge = rx_d & ~rx_s2;
  assign sample     = (cnt == CNT_SAMPLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_d      <= 1'b1;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_int    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_s1     <= rs232_rx;
      rx_s2     <= rx_s1;
      rx_d      <= rx_s2;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif

      // Counter is held at zero in IDLE so each frame times from its own start edge
      if (state == IDLE || cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_edge) state <= START;
        end
        START: begin
          if (sample) begin
            if (!rx_s2) begin
              rx_int  <= 1'b1;
              bit_idx <= 3'd0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample) begin
            par_bit <= rx_s2;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is caught in IDLE
          if (sample) begin
            rx_data   <= shreg;
            rx_int    <= 1'b0;
            frame_err <= ~rx_s2;
`ifdef UART_RX_PARITY_EN
            parity_err <= (^shreg) ^ par_bit;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - bench for uart_rx_core with a frame-queue reference model
// Honours UART_RX_PARITY_EN to send and expect the parity bit.
module tb_uart_rx_core;

  localparam int CLK_FREQ = 1700;
  localparam int BAUD     = 100;
  localparam int BPS      = CLK_FREQ / BAUD;
  localparam int HALF     = BPS / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS   = 11;
  localparam int LAT_LIT = 181;
  localparam int NPAR    = 2;
`else
  localparam int NBITS   = 10;
  localparam int LAT_LIT = 164;
  localparam int NPAR    = 0;
`endif
  localparam int NRAND = 30;
  localparam int LAT   = 3 + HALF + (NBITS - 1) * BPS;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       frame_err;
  logic       parity_err;

  exp_t       q[$];
  exp_t       ab;
  logic [7:0] model_data = 8'h00;
  logic       prev_int = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         falls = 0;
  int         fe_count = 0;
  int         pe_count = 0;
  int         last_fall = 0;
  int         t55 = 0;

  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (line),
    .rx_data   (rx_data),
    .rx_int    (rx_int),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_win(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    exp_t e;
    e.d  = d;
    e.fe = ~stop;
`ifdef UART_RX_PARITY_EN
    e.pe = par ^ (^d);
`else
    e.pe = 1'b0;
`endif
    e.t = cyc;
    q.push_back(e);
    line = 1'b0;
    hold(BPS);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      hold(BPS);
    end
`ifdef UART_RX_PARITY_EN
    line = par;
    hold(BPS);
`endif
    line = stop;
    hold(BPS);
  endtask

  // Reference comparison: every rx_int fall must match the oldest frame sent
  always @(negedge clk) begin
    if (!rst_n) begin
      model_data = 8'h00;
      prev_int   = rx_int;
    end else begin
      if (!prev_int && rx_int) chk("rx_int_rise_pending", int'(q.size() != 0), 1);
      if (prev_int && !rx_int) begin
        falls++;
        last_fall = cyc;
        if (q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rx_data", rx_data, e.d);
          chk("frame_err", frame_err, e.fe);
          chk("parity_err", parity_err, e.pe);
          chk_win("latency", cyc - e.t, LAT, 3);
          model_data = e.d;
        end
      end else begin
        chk("frame_err_quiet", frame_err, 0);
        chk("parity_err_quiet", parity_err, 0);
        chk("rx_data_hold", rx_data, model_data);
      end
      if (frame_err) fe_count++;
      if (parity_err) pe_count++;
      prev_int = rx_int;
    end
  end

  initial begin
    hold(3);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_int", rx_int, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_parity_err", parity_err, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    hold(2 * BPS);

    t55 = cyc;
    send_frame(8'h55, 1'b1, 1'b0);
    chk("first_data", rx_data, 8'h55);
    chk_win("first_latency", last_fall - t55, LAT_LIT, 3);
    chk("first_falls", falls, 1);

    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    chk("b2b_falls", falls, 3);
    chk("b2b_data", rx_data, 8'h0F);

    line = 1'b0;
    hold(4);
    line = 1'b1;
    hold(3 * BPS);
    chk("glitch_falls", falls, 3);
    chk("glitch_rx_int", rx_int, 0);
    chk("glitch_data", rx_data, 8'h0F);

    send_frame(8'h81, 1'b0, 1'b0);
    hold(20 * BPS);
    chk("ferr_falls", falls, 4);
    chk("ferr_pulses", fe_count, 1);
    chk("ferr_data", rx_data, 8'h81);
    chk("ferr_rx_int", rx_int, 0);
    line = 1'b1;
    hold(2 * BPS);

    ab.d  = 8'h3C;
    ab.fe = 1'b0;
    ab.pe = 1'b0;
    ab.t  = cyc;
    q.push_back(ab);
    line = 1'b0;
    hold(BPS);
    for (int i = 0; i < 4; i++) begin
      line = ab.d[i];
      hold(BPS);
    end
    line = ab.d[4];
    hold(HALF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    line = 1'b1;
    hold(3);
    chk("midreset_rx_data", rx_data, 8'h00);
    chk("midreset_rx_int", rx_int, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    hold(3 * BPS);
    chk("post_reset_falls", falls, 4);
    chk("post_reset_data", rx_data, 8'h00);
    send_frame(8'hC3, 1'b1, 1'b0);
    chk("post_reset_c3", rx_data, 8'hC3);
    chk("post_reset_c3_falls", falls, 5);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    chk("parity_bad_pulses", pe_count, 1);
    chk("parity_bad_data", rx_data, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    chk("parity_good_pulses", pe_count, 1);
`endif

    for (int n = 0; n < NRAND; n++) begin
      logic [7:0] d;
      logic       stop;
      logic       par;
      d    = 8'($urandom);
      stop = ($urandom_range(7) != 0);
      par  = (^d) ^ ($urandom_range(3) == 0);
      send_frame(d, stop, par);
      if (!stop) begin
        line = 1'b1;
        hold(BPS + $urandom_range(BPS));
      end else begin
        hold($urandom_range(2 * BPS));
      end
    end
    line = 1'b1;
    hold(2 * BPS);
    chk("total_falls", falls, 5 + NPAR + NRAND);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
